// File: rtl/led_blink_ctrl_pkg.sv
// Shared definitions for the fabric LED controller: channel modes,
// reset defaults and the prescaler divide helper.
package led_blink_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PWM   = 2'd3
   } mode_e;

   localparam int DEF_CHANNELS    = 4;
   localparam int DEF_CLK_FREQ_HZ = 50_000_000;
   localparam int DEF_TICK_HZ     = 1000;
   localparam int DEF_CNT_W       = 16;
   localparam int DEF_PWM_W       = 8;
   localparam int DEF_RST_PERIOD  = 500;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   // Channel select width never drops below one bit, even for a single channel.
   function automatic int calc_ch_w(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Config/run-control bus between the MSS glue (master) and the LED block (slave).
interface led_blink_ctrl_if
   import led_blink_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int CH_W     = calc_ch_w(CHANNELS),
   parameter int CNT_W    = DEF_CNT_W,
   parameter int PWM_W    = DEF_PWM_W
);
   logic                MSS_READY;
   logic                SYNC;
   logic                WR_EN;
   logic [CH_W-1:0]     WR_CH;
   logic [1:0]          WR_MODE;
   logic [CNT_W-1:0]    WR_PERIOD;
   logic [PWM_W-1:0]    WR_DUTY;
   logic [CHANNELS-1:0] LED;
   logic                TICK;

   modport master (
      output MSS_READY, SYNC, WR_EN, WR_CH, WR_MODE, WR_PERIOD, WR_DUTY,
      input  LED, TICK
   );

   modport slave (
      input  MSS_READY, SYNC, WR_EN, WR_CH, WR_MODE, WR_PERIOD, WR_DUTY,
      output LED, TICK
   );
endinterface

// File: rtl/led_blink_ctrl_channel.sv
// One LED channel: config registers, blink phase/state and the registered LED bit.
module led_channel
   import led_blink_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int PWM_W      = DEF_PWM_W,
   parameter int RST_PERIOD = DEF_RST_PERIOD
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ready,
   input  logic             i_sync,
   input  logic             i_tick,
   input  logic [PWM_W-1:0] i_pwm_cnt,
   input  logic             i_wr_en,
   input  logic [1:0]       i_wr_mode,
   input  logic [CNT_W-1:0] i_wr_period,
   input  logic [PWM_W-1:0] i_wr_duty,
   output logic             o_led
);
   mode_e            r_mode;
   logic [CNT_W-1:0] r_period;
   logic [PWM_W-1:0] r_duty;
   logic [CNT_W-1:0] r_phase;
   logic             r_blink;
   logic             r_led;
   logic [CNT_W-1:0] w_last_phase;

   // A zero period is treated as one tick per half-period.
   assign w_last_phase = (r_period == '0) ? '0 : r_period - 1'b1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mode   <= MODE_OFF;
         r_period <= CNT_W'(RST_PERIOD);
         r_duty   <= '0;
         r_phase  <= '0;
         r_blink  <= 1'b0;
         r_led    <= 1'b0;
      end else begin
         if (!i_ready) begin
            r_led <= 1'b0;
         end else begin
            case (r_mode)
               MODE_OFF:   r_led <= 1'b0;
               MODE_ON:    r_led <= 1'b1;
               MODE_BLINK: r_led <= r_blink;
               MODE_PWM:   r_led <= (i_pwm_cnt < r_duty);
               default:    r_led <= 1'b0;
            endcase
         end

         if (i_wr_en) begin
            r_mode   <= mode_e'(i_wr_mode);
            r_period <= i_wr_period;
            r_duty   <= i_wr_duty;
         end

         // Sync, a config write or run-disable all restart the blink from phase 0.
         if (i_wr_en || i_sync || !i_ready) begin
            r_phase <= '0;
            r_blink <= 1'b0;
         end else if (i_tick && (r_mode == MODE_BLINK)) begin
            if (r_phase == w_last_phase) begin
               r_phase <= '0;
               r_blink <= ~r_blink;
            end else begin
               r_phase <= r_phase + 1'b1;
            end
         end
      end
   end

   assign o_led = r_led;

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED controller top: shared prescaler tick and PWM counter
// feeding one led_channel per LED output.
module led_blink_ctrl
   import led_blink_pkg::*;
#(
   parameter int CHANNELS    = DEF_CHANNELS,
   parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
   parameter int TICK_HZ     = DEF_TICK_HZ,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int PWM_W       = DEF_PWM_W,
   parameter int RST_PERIOD  = DEF_RST_PERIOD
) (
   input  logic            CLK_BASE,
   input  logic            FAB_RESET,
   led_blink_ctrl_if.slave bus
);
   localparam int DIV   = calc_div(CLK_FREQ_HZ, TICK_HZ);
   localparam int DIV_W = $clog2(DIV);
   localparam int CH_W  = calc_ch_w(CHANNELS);

   logic [DIV_W-1:0]    r_presc;
   logic                r_tick;
   logic [PWM_W-1:0]    r_pwm_cnt;
   logic [CHANNELS-1:0] w_led;

   // Run-disable and sync both park the time base at zero with no tick.
   always_ff @(posedge CLK_BASE or posedge FAB_RESET) begin
      if (FAB_RESET) begin
         r_presc   <= '0;
         r_tick    <= 1'b0;
         r_pwm_cnt <= '0;
      end else if (!bus.MSS_READY || bus.SYNC) begin
         r_presc   <= '0;
         r_tick    <= 1'b0;
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         if (r_presc == DIV_W'(DIV - 1)) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
         end else begin
            r_presc <= r_presc + 1'b1;
            r_tick  <= 1'b0;
         end
      end
   end

   // Out-of-range channel numbers match no instance, so such writes are dropped.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic w_wr_sel;
      assign w_wr_sel = bus.WR_EN && (bus.WR_CH == CH_W'(gi));

      led_channel #(
         .CNT_W      (CNT_W),
         .PWM_W      (PWM_W),
         .RST_PERIOD (RST_PERIOD)
      ) u_ch (
         .i_clk       (CLK_BASE),
         .i_rst       (FAB_RESET),
         .i_ready     (bus.MSS_READY),
         .i_sync      (bus.SYNC),
         .i_tick      (r_tick),
         .i_pwm_cnt   (r_pwm_cnt),
         .i_wr_en     (w_wr_sel),
         .i_wr_mode   (bus.WR_MODE),
         .i_wr_period (bus.WR_PERIOD),
         .i_wr_duty   (bus.WR_DUTY),
         .o_led       (w_led[gi])
      );
   end

   assign bus.LED  = w_led;
   assign bus.TICK = r_tick;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scenario bench for led_blink_ctrl with DIV=10 and five channels.
module tb_led_blink_ctrl;
   import led_blink_pkg::*;

   localparam int CHANNELS = 5;
   localparam int CH_W     = 3;
   localparam int CNT_W    = 16;
   localparam int PWM_W    = 8;
   localparam logic [31:0] TIMEOUT = 32'hFFFF_FFFF;

   logic clk;
   logic rst;

   led_blink_ctrl_if #(.CHANNELS(CHANNELS), .CH_W(CH_W), .CNT_W(CNT_W), .PWM_W(PWM_W)) bus ();

   led_blink_ctrl #(
      .CHANNELS    (CHANNELS),
      .CLK_FREQ_HZ (1000),
      .TICK_HZ     (100),
      .CNT_W       (CNT_W),
      .PWM_W       (PWM_W),
      .RST_PERIOD  (500)
   ) dut (
      .CLK_BASE  (clk),
      .FAB_RESET (rst),
      .bus       (bus)
   );

   logic [31:0] exp_q[$];
   logic [31:0] exp;
   logic [31:0] obs;
   int vectors;
   int miscompares;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(output logic [31:0] n);
      n = TIMEOUT;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (bus.TICK === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_led(input int b, input logic v, output logic [31:0] n);
      n = TIMEOUT;
      for (int i = 1; i <= 600; i++) begin
         step();
         if (bus.LED[b] === v) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wr(input int ch, input logic [1:0] mode, input int period, input int duty);
      bus.WR_EN     = 1'b1;
      bus.WR_CH     = CH_W'(ch);
      bus.WR_MODE   = mode;
      bus.WR_PERIOD = CNT_W'(period);
      bus.WR_DUTY   = PWM_W'(duty);
      step();
      bus.WR_EN     = 1'b0;
      $display("write ch=%0d mode=%0d period=%0d duty=%0d", ch, mode, period, duty);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      obs = 32'(bus.LED); exp = exp_q.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL reset_led: got %0h expected %0h", obs, exp); end
      else $display("reset_led ok: %0h", obs);
      obs = 32'(bus.TICK); exp = exp_q.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL reset_tick: got %0h expected %0h", obs, exp); end
      else $display("reset_tick ok: %0h", obs);
      rst = 1'b0;
      // first tick 10 clocks after release, then every 10 clocks
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(32'd10);
         wait_tick(obs);
         exp = exp_q.pop_front(); vectors++;
         if (obs !== exp) begin miscompares++; $display("FAIL tick_interval%0d: got %0d expected %0d", k, obs, exp); end
         else $display("tick_interval%0d ok: %0d clocks", k, obs);
      end
   endtask

   task automatic test_blink();
      wr(0, MODE_BLINK, 3, 0);
      step();
      exp_q.push_back(32'd0);
      obs = 32'(bus.LED[0]); exp = exp_q.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL blink_start: got %0h expected %0h", obs, exp); end
      else $display("blink_start ok: %0h", obs);
      wait_led(0, 1'b1, obs);
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(32'd30);
         wait_led(0, (k == 0) ? 1'b0 : 1'b1, obs);
         exp = exp_q.pop_front(); vectors++;
         if (obs !== exp) begin miscompares++; $display("FAIL blink_p3_half%0d: got %0d expected %0d", k, obs, exp); end
         else $display("blink_p3_half%0d ok: %0d clocks", k, obs);
      end
      wr(0, MODE_BLINK, 0, 0);
      wait_led(0, 1'b1, obs);
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(32'd10);
         wait_led(0, (k == 0) ? 1'b0 : 1'b1, obs);
         exp = exp_q.pop_front(); vectors++;
         if (obs !== exp) begin miscompares++; $display("FAIL blink_p0_half%0d: got %0d expected %0d", k, obs, exp); end
         else $display("blink_p0_half%0d ok: %0d clocks", k, obs);
      end
   endtask

   task automatic test_pwm();
      int duties [3];
      duties = '{64, 255, 0};
      for (int k = 0; k < 3; k++) begin
         wr(1, MODE_PWM, 500, duties[k]);
         step();
         exp_q.push_back(32'(duties[k]));
         obs = 0;
         for (int i = 0; i < 256; i++) begin
            step();
            if (bus.LED[1] === 1'b1) obs++;
         end
         exp = exp_q.pop_front(); vectors++;
         if (obs !== exp) begin miscompares++; $display("FAIL pwm_duty%0d: got %0d high expected %0d", duties[k], obs, exp); end
         else $display("pwm_duty%0d ok: %0d high of 256", duties[k], obs);
      end
   endtask

   task automatic test_on_off_ignore();
      int bad_ch [3];
      bad_ch = '{-1, 5, 7};
      wr(2, MODE_ON, 500, 0);
      wr(3, MODE_OFF, 500, 0);
      // ch4 OFF, ch3 OFF, ch2 ON, ch1 PWM with duty 0
      for (int k = 0; k < 3; k++) begin
         if (bad_ch[k] >= 0) wr(bad_ch[k], MODE_ON, 1, 255);
         step();
         step();
         exp_q.push_back(32'b0010);
         obs = 32'(bus.LED[4:1]);
         exp = exp_q.pop_front(); vectors++;
         if (obs !== exp) begin miscompares++; $display("FAIL on_off_after_ch%0d: got %b expected %b", bad_ch[k], obs[3:0], exp[3:0]); end
         else $display("on_off_after_ch%0d ok: LED[4:1]=%b", bad_ch[k], obs[3:0]);
      end
   endtask

   task automatic test_sync();
      logic [31:0] m;
      wr(0, MODE_BLINK, 3, 0);
      wait_led(0, 1'b1, m);
      wait_led(0, 1'b0, m);
      // two non-toggling ticks, then SYNC lands on the tick that would toggle
      wait_tick(m);
      wait_tick(m);
      wait_tick(m);
      bus.SYNC = 1'b1;
      step();
      bus.SYNC = 1'b0;
      step();
      exp_q.push_back(32'd0);
      obs = 32'(bus.LED[0]); exp = exp_q.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL sync_no_toggle: got %0h expected %0h", obs, exp); end
      else $display("sync_no_toggle ok: %0h", obs);
      // 3 ticks of 10 clocks plus tick-register and LED-register latency
      exp_q.push_back(32'd32);
      wait_led(0, 1'b1, m);
      obs = (m == TIMEOUT) ? TIMEOUT : m + 1;
      exp = exp_q.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL sync_next_toggle: got %0d expected %0d", obs, exp); end
      else $display("sync_next_toggle ok: %0d clocks", obs);
   endtask

   task automatic test_ready();
      logic [31:0] m;
      bus.MSS_READY = 1'b0;
      step();
      exp_q.push_back(32'd0);
      obs = 32'(bus.LED); exp = exp_q.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL ready_low_led: got %0h expected %0h", obs, exp); end
      else $display("ready_low_led ok: %0h", obs);
      exp_q.push_back(32'd0);
      obs = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.TICK !== 1'b0 || bus.LED !== '0) obs = 1;
      end
      exp = exp_q.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL ready_low_hold: got %0h expected %0h", obs, exp); end
      else $display("ready_low_hold ok");
      bus.MSS_READY = 1'b1;
      step();
      exp_q.push_back(32'b00100);
      obs = 32'(bus.LED); exp = exp_q.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL ready_rise_led: got %b expected %b", obs[4:0], exp[4:0]); end
      else $display("ready_rise_led ok: %b", obs[4:0]);
      exp_q.push_back(32'd32);
      wait_led(0, 1'b1, m);
      obs = (m == TIMEOUT) ? TIMEOUT : m + 1;
      exp = exp_q.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL ready_restart: got %0d expected %0d", obs, exp); end
      else $display("ready_restart ok: %0d clocks", obs);
   endtask

   task automatic test_fab_reset();
      #3;
      rst = 1'b1;
      #1;
      exp_q.push_back(32'd0);
      obs = 32'(bus.LED); exp = exp_q.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL async_reset_led: got %0h expected %0h", obs, exp); end
      else $display("async_reset_led ok: %0h", obs);
      step();
      step();
      rst = 1'b0;
      // config must be back to OFF everywhere: nothing lights up
      exp_q.push_back(32'd0);
      obs = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         obs = obs | 32'(bus.LED);
      end
      exp = exp_q.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL reset_config_off: got %b expected %b", obs[4:0], exp[4:0]); end
      else $display("reset_config_off ok");
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b1;
      bus.MSS_READY = 1'b1;
      bus.SYNC      = 1'b0;
      bus.WR_EN     = 1'b0;
      bus.WR_CH     = '0;
      bus.WR_MODE   = 2'd0;
      bus.WR_PERIOD = '0;
      bus.WR_DUTY   = '0;
      test_reset();
      test_blink();
      test_pwm();
      test_on_off_ignore();
      test_sync();
      test_ready();
      test_fab_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
